// File: rtl/mul6_error_accumulator_if.sv
// mul6_error_accumulator_if: sample stream carrying an operand pair and its approximate product
interface mul6_error_accumulator_if #(
    parameter int W = 6
) ();
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [2*W-1:0] approx_p;

    modport master (output in_valid, op_a, op_b, approx_p, input in_ready);
    modport slave  (input in_valid, op_a, op_b, approx_p, output in_ready);
endinterface

// File: rtl/mul6_error_accumulator.sv
// mul6_error_accumulator: windowed error metrics of an approximate WxW multiplier against the exact product
module mul6_error_accumulator #(
    parameter int W     = 6,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     start,
    input  logic [CNT_W-1:0]         n_samples,
    mul6_error_accumulator_if.slave  smp,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [2*W+CNT_W-1:0]     sum_ed,
    output logic [2*W-1:0]           max_ed,
    output logic [2*W+CNT_W:0]       bias
);
    localparam int P  = 2 * W;
    localparam int SW = P + CNT_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;

    logic [CNT_W-1:0] n_lat, acc_cnt, acc_n, n_n;
    logic [P-1:0]     exact_r, approx_r, ed;
    logic [P:0]       d_r;
    logic             v1, v2, xfer, go, last;

    assign xfer  = smp.in_valid & smp.in_ready;
    assign go    = start & (state == IDLE || state == DONE);
    assign acc_n = go ? '0 : acc_cnt + CNT_W'(xfer);
    assign n_n   = go ? n_samples : n_lat;
    assign last  = (state == RUN) && xfer && (acc_n == n_lat);
    assign ed    = d_r[P] ? P'(-d_r) : d_r[P-1:0];
    assign busy  = (state == RUN) || (state == DRAIN);

    always_comb begin
        state_n = go ? (n_samples == '0 ? DONE : RUN) :
                  last ? DRAIN :
                  (state == DRAIN && !v1 && !v2) ? DONE : state;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) state <= IDLE;
        else              state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            smp.in_ready <= 1'b0;
            done         <= 1'b0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            exact_r      <= '0;
            approx_r     <= '0;
            d_r          <= '0;
            acc_cnt      <= '0;
            n_lat        <= '0;
            sample_cnt   <= '0;
            err_cnt      <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
            bias         <= '0;
        end else begin
            // a zero-length window restarted from DONE still needs its own done pulse
            done         <= (state_n == DONE) && (state != DONE || go);
            smp.in_ready <= (state_n == RUN) && (acc_n < n_n);
            acc_cnt      <= acc_n;
            n_lat        <= n_n;
            v1           <= xfer;
            exact_r      <= P'(smp.op_a) * P'(smp.op_b);
            approx_r     <= smp.approx_p;
            v2           <= v1;
            d_r          <= {1'b0, approx_r} - {1'b0, exact_r};
            if (go) begin
                sample_cnt <= '0;
                err_cnt    <= '0;
                sum_ed     <= '0;
                max_ed     <= '0;
                bias       <= '0;
            end else if (v2) begin
                sample_cnt <= sample_cnt + 1'b1;
                err_cnt    <= err_cnt + CNT_W'(d_r != '0);
                sum_ed     <= sum_ed + SW'(ed);
                max_ed     <= (ed > max_ed) ? ed : max_ed;
                bias       <= bias + {{(SW - P){d_r[P]}}, d_r};
            end
        end
    end
endmodule

// File: tb/tb_mul6_error_accumulator.sv
// tb_mul6_error_accumulator: directed windows; expected totals queued at start, checked on each done pulse
module tb_mul6_error_accumulator;
    logic        clk = 0;
    logic        rst = 1;
    logic        clear = 0;
    logic        start = 0;
    logic [15:0] n_samples = 0;
    logic        busy, done;
    logic [15:0] sample_cnt, err_cnt;
    logic [27:0] sum_ed;
    logic [11:0] max_ed;
    logic [28:0] bias;

    mul6_error_accumulator_if #(.W(6)) bus ();

    mul6_error_accumulator dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .n_samples(n_samples),
        .smp(bus), .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .sum_ed(sum_ed), .max_ed(max_ed), .bias(bias)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint sc;
        longint ec;
        longint sum;
        longint mx;
        longint bs;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pushes = 0;
    int   dones = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            dones++;
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("sample_cnt", longint'(sample_cnt), e.sc);
                chk("err_cnt", longint'(err_cnt), e.ec);
                chk("sum_ed", longint'(sum_ed), e.sum);
                chk("max_ed", longint'(max_ed), e.mx);
                chk("bias", longint'($signed(bias)), e.bs);
            end
        end
    end

    task automatic start_win(input int n, input longint sc, ec, sum, mx, bs);
        exp_t e;
        e = '{sc, ec, sum, mx, bs};
        @(negedge clk);
        start = 1;
        n_samples = 16'(n);
        q.push_back(e);
        pushes++;
        @(negedge clk);
        start = 0;
    endtask

    task automatic send(input int a, input int b, input int p);
        int k;
        @(negedge clk);
        bus.in_valid = 1;
        bus.op_a = 6'(a);
        bus.op_b = 6'(b);
        bus.approx_p = 12'(p);
        for (k = 0; k < 200 && !bus.in_ready; k++) @(negedge clk);
        if (k == 200) chk("ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            chk("done_timeout", longint'(q.size()), 0);
            q.delete();
        end
    endtask

    initial begin
        bus.in_valid = 0;
        bus.op_a = 0;
        bus.op_b = 0;
        bus.approx_p = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_bias", bias, 0);

        // 1) exact approximations
        start_win(4, 4, 0, 0, 0, 0);
        send(3, 5, 15); send(63, 63, 3969); send(0, 17, 0); send(8, 8, 64);
        idle();
        wait_done();

        // 2) d = -3, -1, +4
        start_win(3, 3, 3, 8, 4, 0);
        send(7, 9, 60); send(63, 63, 3968); send(2, 2, 8);
        idle();
        wait_done();

        // 3) bubbles, stall, and offers beyond the window
        start_win(2, 2, 1, 1, 1, 1);
        send(1, 1, 1);
        idle();
        repeat (5) @(negedge clk);
        send(2, 3, 7);
        idle();
        chk("ready_after_last", bus.in_ready, 0);
        repeat (3) begin
            @(negedge clk);
            bus.in_valid = 1;
            bus.op_a = 5;
            bus.op_b = 5;
            bus.approx_p = 0;
            chk("ready_while_offered", bus.in_ready, 0);
            @(negedge clk);
            bus.in_valid = 0;
        end
        wait_done();

        // 4) zero-length window
        start_win(0, 0, 0, 0, 0, 0);
        chk("n0_done_next", done, 1);
        chk("n0_in_ready", bus.in_ready, 0);
        wait_done();

        // 5) clear mid-window, then a fresh window with negative bias
        @(negedge clk);
        start = 1;
        n_samples = 5;
        @(negedge clk);
        start = 0;
        send(4, 4, 0); send(5, 5, 0);
        @(negedge clk);
        bus.in_valid = 0;
        clear = 1;
        @(negedge clk);
        clear = 0;
        repeat (4) @(negedge clk);
        chk("clr_busy", busy, 0);
        chk("clr_in_ready", bus.in_ready, 0);
        chk("clr_sample_cnt", sample_cnt, 0);
        chk("clr_sum_ed", sum_ed, 0);
        @(negedge clk);
        start = 1;
        clear = 1;
        n_samples = 3;
        @(negedge clk);
        start = 0;
        clear = 0;
        chk("clr_beats_start", busy, 0);
        start_win(1, 1, 1, 3, 3, -3);
        send(1, 3, 0);
        idle();
        wait_done();

        // 6) exhaustive sweep with LSB-flipped products, restarted straight from DONE
        start_win(4096, 4096, 4096, 4096, 1, 2048);
        for (int a = 0; a < 64; a++)
            for (int b = 0; b < 64; b++)
                send(a, b, (a * b) ^ 1);
        idle();
        wait_done();
        start_win(4, 4, 0, 0, 0, 0);
        send(3, 5, 15); send(63, 63, 3969); send(0, 17, 0); send(8, 8, 64);
        idle();
        wait_done();
        repeat (3) @(negedge clk);
        chk("done_pulses", dones, pushes);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
